// File: rtl/counter_monitor_pkg.sv
// Shared types for the counter_monitor observer: FSM states and error codes.
package counter_monitor_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_RESET_VAL = 2'd1,
    ERR_STEP      = 2'd2,
    ERR_HOLD      = 2'd3
  } err_code_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q != '1)) begin
      q_d = q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Observer for an up-counter: resyncing reference model, per-event error pulse,
// sticky flag, first bad value and saturating error/wrap statistics.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up,
  input  logic [WIDTH-1:0]      dout,
  input  logic                  chk_en,
  input  logic                  clr,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      exp_dout,
  output logic [WIDTH-1:0]      first_err_val,
  output state_t                dbg_state
);

  state_t           state_q;
  logic [WIDTH-1:0] prev_dout_q;
  logic             prev_up_q;
  logic             err_pulse_q;
  err_code_t        err_code_q;
  logic             err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] first_err_q, first_err_d;
  logic [WIDTH-1:0] exp_dout_q;

  logic [WIDTH-1:0] exp_model;
  err_code_t        viol_code;
  logic             viol;
  logic             wrap;

  // Model value for the current sample, built from the previous sample only.
  always_comb begin
    exp_model = prev_up_q ? (prev_dout_q + WIDTH'(1)) : prev_dout_q;
    viol_code = ERR_NONE;
    if (chk_en) begin
      if (state_q == S_INIT) begin
        if (dout != '0) viol_code = ERR_RESET_VAL;
      end else if (dout != exp_model) begin
        viol_code = prev_up_q ? ERR_STEP : ERR_HOLD;
      end
    end
  end

  assign viol = (viol_code != ERR_NONE);
  assign wrap = (state_q == S_TRACK) && prev_up_q && (&prev_dout_q) && (dout == '0);

  always_comb begin
    err_sticky_d = err_sticky_q;
    first_err_d  = first_err_q;
    if (clr) begin
      err_sticky_d = 1'b0;
      first_err_d  = '0;
    end else if (viol) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q) first_err_d = dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      prev_dout_q  <= '0;
      prev_up_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
      first_err_q  <= '0;
      exp_dout_q   <= '0;
    end else begin
      state_q      <= S_TRACK;
      prev_dout_q  <= dout;
      prev_up_q    <= up;
      err_pulse_q  <= viol;
      err_code_q   <= viol_code;
      err_sticky_q <= err_sticky_d;
      first_err_q  <= first_err_d;
      exp_dout_q   <= up ? (dout + WIDTH'(1)) : dout;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (viol),
    .clr (clr),
    .q   (err_count)
  );

  // Wraps are statistics of the observed counter, so clr leaves them alone.
  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap),
    .clr (1'b0),
    .q   (wrap_count)
  );

  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;
  assign err_sticky    = err_sticky_q;
  assign exp_dout      = exp_dout_q;
  assign first_err_val = first_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor; a second instance with a 2-bit error
// counter shares the stimulus to exercise saturation.
module tb_counter_monitor;
  import counter_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0;
  logic [3:0] dout = 4'd0;
  logic       chk_en = 1'b1;
  logic       clr = 1'b0;

  logic       err_pulse, err_sticky;
  logic [1:0] err_code;
  logic [7:0] err_count, wrap_count;
  logic [3:0] exp_dout, first_err_val;
  state_t     dbg_state;

  logic       s_err_pulse, s_err_sticky;
  logic [1:0] s_err_code;
  logic [1:0] s_err_count;
  logic [7:0] s_wrap_count;
  logic [3:0] s_exp_dout, s_first_err_val;
  state_t     s_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_monitor dut (
    .clk(clk), .rst(rst), .up(up), .dout(dout), .chk_en(chk_en), .clr(clr),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_count(wrap_count), .exp_dout(exp_dout),
    .first_err_val(first_err_val), .dbg_state(dbg_state)
  );

  counter_monitor #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .up(up), .dout(dout), .chk_en(chk_en), .clr(clr),
    .err_pulse(s_err_pulse), .err_code(s_err_code), .err_sticky(s_err_sticky),
    .err_count(s_err_count), .wrap_count(s_wrap_count), .exp_dout(s_exp_dout),
    .first_err_val(s_first_err_val), .dbg_state(s_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one sample: inputs change just after a rising edge, outputs read 1ns after the next.
  task automatic step(input logic u, input logic [3:0] d, input logic en, input logic c);
    up = u; dout = d; chk_en = en; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pulse"},  32'(err_pulse), 0);
    check({tag, ".code"},   32'(err_code), 0);
    check({tag, ".sticky"}, 32'(err_sticky), 0);
    check({tag, ".count"},  32'(err_count), 0);
    check({tag, ".wrap"},   32'(wrap_count), 0);
    check({tag, ".exp"},    32'(exp_dout), 0);
    check({tag, ".first"},  32'(first_err_val), 0);
    check({tag, ".state"},  32'(dbg_state), 32'(S_INIT));
  endtask

  initial begin
    // 1: reset, then a correct counter counting 0..20 (wraps once, ends at 4)
    apply_rst(3);
    rst = 1'b1;
    #1;
    check_all_zero("rst");
    rst = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      step(1'b1, 4'(i), 1'b1, 1'b0);
      check($sformatf("t1.pulse%0d", i), 32'(err_pulse), 0);
    end
    check("t1.count",  32'(err_count), 0);
    check("t1.wrap",   32'(wrap_count), 1);
    check("t1.sticky", 32'(err_sticky), 0);
    check("t1.exp",    32'(exp_dout), 5);
    check("t1.state",  32'(dbg_state), 32'(S_TRACK));

    // 2: counter reached 5 and holds with up=0
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd5, 1'b1, 1'b0);
      check($sformatf("t2.pulse%0d", i), 32'(err_pulse), 0);
      check($sformatf("t2.exp%0d", i),   32'(exp_dout), 5);
    end

    // 3: up=1 at 5, then 7 shows up where 6 is due
    step(1'b1, 4'd5, 1'b1, 1'b0);
    check("t3.exp6",   32'(exp_dout), 6);
    step(1'b1, 4'd7, 1'b1, 1'b0);
    check("t3.pulse",  32'(err_pulse), 1);
    check("t3.code",   32'(err_code), 2);
    check("t3.count",  32'(err_count), 1);
    check("t3.sticky", 32'(err_sticky), 1);
    check("t3.first",  32'(first_err_val), 7);
    check("t3.exp8",   32'(exp_dout), 8);

    // 4: resynced model accepts 8, then 8->9 with up=0 is a hold fault
    step(1'b0, 4'd8, 1'b1, 1'b0);
    check("t4.pulse0", 32'(err_pulse), 0);
    check("t4.code0",  32'(err_code), 0);
    step(1'b0, 4'd9, 1'b1, 1'b0);
    check("t4.pulse",  32'(err_pulse), 1);
    check("t4.code",   32'(err_code), 3);
    check("t4.count",  32'(err_count), 2);
    check("t4.first",  32'(first_err_val), 7);
    step(1'b0, 4'd9, 1'b1, 1'b1);
    check("t4.clr_pulse",  32'(err_pulse), 0);
    check("t4.clr_sticky", 32'(err_sticky), 0);
    check("t4.clr_count",  32'(err_count), 0);
    check("t4.clr_first",  32'(first_err_val), 0);
    check("t4.clr_wrap",   32'(wrap_count), 1);

    // 5a: nonzero first sample after reset
    apply_rst(2);
    step(1'b0, 4'd3, 1'b1, 1'b0);
    check("t5.pulse", 32'(err_pulse), 1);
    check("t5.code",  32'(err_code), 1);
    check("t5.count", 32'(err_count), 1);
    check("t5.first", 32'(first_err_val), 3);
    check("t5.exp",   32'(exp_dout), 3);

    // 5b: same with checking off, illegal jumps resync silently, wraps still counted
    apply_rst(2);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    check("t5b.pulse", 32'(err_pulse), 0);
    check("t5b.exp4",  32'(exp_dout), 4);
    step(1'b0, 4'd9, 1'b0, 1'b0);
    check("t5b.exp9",  32'(exp_dout), 9);
    step(1'b0, 4'd9, 1'b1, 1'b0);
    check("t5b.reen_pulse", 32'(err_pulse), 0);
    check("t5b.reen_count", 32'(err_count), 0);
    step(1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    check("t5b.wrap",  32'(wrap_count), 1);
    check("t5b.count", 32'(err_count), 0);
    step(1'b0, 4'd15, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t5b.badwrap_code", 32'(err_code), 3);
    check("t5b.badwrap_wrap", 32'(wrap_count), 1);
    step(1'b0, 4'd5, 1'b1, 1'b1);
    check("t5b.clrviol_pulse",  32'(err_pulse), 1);
    check("t5b.clrviol_code",   32'(err_code), 3);
    check("t5b.clrviol_count",  32'(err_count), 0);
    check("t5b.clrviol_sticky", 32'(err_sticky), 0);
    check("t5b.clrviol_first",  32'(first_err_val), 0);

    // 6: five hold faults saturate the 2-bit counter, then async reset mid-cycle
    apply_rst(2);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t6.init_pulse", 32'(err_pulse), 0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 4'(i), 1'b1, 1'b0);
      check($sformatf("t6.pulse%0d", i), 32'(s_err_pulse), 1);
    end
    check("t6.sat_count",  32'(s_err_count), 3);
    check("t6.wide_count", 32'(err_count), 5);
    check("t6.sat_first",  32'(s_first_err_val), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6.async");
    check("t6.sat_async_count", 32'(s_err_count), 0);
    check("t6.sat_async_state", 32'(s_dbg_state), 32'(S_INIT));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t6.restart_pulse", 32'(err_pulse), 0);
    step(1'b0, 4'd2, 1'b1, 1'b0);
    check("t6.restart_code",  32'(err_code), 3);
    check("t6.restart_count", 32'(err_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
